prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 8: log2 of instruction store depth in 32-bit words.
REQ-002 SHALL have parameter RESET_HOLD, default 4: cycles `core_reset` stays high after fill completes, range 1..15.
REQ-003 SHALL have port `clock`, input, 1: rising-edge clock.
REQ-004 SHALL have port `reset`, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port `load_valid`, input, 1: load word offered.
REQ-006 SHALL have port `load_ready`, output, 1: loader accepts word this cycle.
REQ-007 SHALL have port `load_data`, input, 32: instruction word.
REQ-008 SHALL have port `load_last`, input, 1: final word of program, qualified by the handshake.
REQ-009 SHALL have port `fetch_addr`, input, 32: core word address, equal to pc>>2.
REQ-010 SHALL have port `fetch_instr`, output, 32: instruction at `fetch_addr`.
REQ-011 SHALL have port `core_reset`, output, 1: reset driven to the core.
REQ-012 SHALL have port `loaded_words`, output, DEPTH_LOG2+1: count of accepted words.
REQ-013 SHALL have port `load_error`, output, 1: sticky overflow or checksum failure.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, FILL, HOLD, RUN, ERROR.
- IDLE->LOAD on the first `load_valid`.
- LOAD->FILL on an accepted word with `load_last`=1.
- FILL->HOLD when the zero-fill pointer wraps to 0.
- HOLD->RUN after RESET_HOLD cycles.
- LOAD->ERROR when 2**DEPTH_LOG2 words are accepted without `load_last`.
REQ-015 SHALL treat a word as accepted only when `load_valid` and `load_ready` are both 1 on a rising edge; `load_ready`=1 only in IDLE and LOAD.
REQ-016 SHALL write an accepted word to store[wptr] and increment wptr and `loaded_words` in the same cycle; zero-length programs are impossible, since `load_last` on the first word yields a 1-word program.
REQ-017 SHALL, in FILL, write 0 to store[wptr] once per cycle until wptr wraps; if the program filled every entry, FILL SHALL last 0 cycles.
REQ-018 SHALL drive `fetch_instr` combinationally as store[fetch_addr[DEPTH_LOG2-1:0]] in RUN, ignoring upper address bits (wrap), and as 0 in every other state.
REQ-019 SHALL hold `core_reset`=1 in every state except RUN; ERROR is terminal until `reset`.
REQ-020 SHALL ignore `load_valid` in FILL, HOLD, RUN and ERROR, with no writes and no count change.

Reset
REQ-021 SHALL, on `reset`, enter IDLE with wptr=0, hold counter=0, `loaded_words`=0, `load_error`=0, `core_reset`=1, `load_ready`=1 and `fetch_instr`=0 (mid-load or mid-run alike).
REQ-022 SHALL NOT clear store contents on `reset`; the next load overwrites them.

Configuration
REQ-023 SHALL, when PROG_LOADER_CHECKSUM_EN is defined, add input `load_checksum` (32), sampled with the last word.
- Running XOR of all accepted words is compared against it.
- Mismatch: state ERROR, `load_error`=1.
- Match: state FILL.
REQ-024 SHALL, when PROG_LOADER_CHECKSUM_EN is undefined, omit the `load_checksum` port and all checksum logic.

Structure
REQ-025 SHALL place the state enum and the FETCH_IDLE_WORD=32'h0 constant in package prog_loader_pkg.
REQ-026 SHALL contain one sub-module, prog_loader_mem: single-port synchronous write, asynchronous read, depth 2**DEPTH_LOG2, width 32.

Verification
REQ-027 SHALL cover a program load:
- Stimulus: 9 words back-to-back, 0x00631826 ... 0x0040000d, with `load_last` on word 9.
- Response: `loaded_words`=9, 247 FILL cycles, `core_reset` falls exactly 4 cycles later, `fetch_addr`=1 -> 0x2063000a, `fetch_addr`=9 -> 0.
REQ-028 SHALL cover backpressure: `load_valid` toggled every other cycle for 3 words -> exactly 3 writes, `loaded_words`=3, no duplicates.
REQ-029 SHALL cover overflow: DEPTH_LOG2=2 and 5 words without `load_last` -> ERROR after the 4th acceptance, `load_ready`=0, `load_error`=1, `core_reset` stays 1.
REQ-030 SHALL cover reset mid-load: `reset` after 3 words, then reload of 2 words -> `loaded_words`=2, store[2..] zero-filled.
REQ-031 SHALL cover address wrap: in RUN with DEPTH_LOG2=8, `fetch_addr`=0x101 -> store[1].
REQ-032 SHALL cover checksum, with PROG_LOADER_CHECKSUM_EN defined: words 0x1 and 0x2 with `load_checksum`=0x3 -> RUN; with `load_checksum`=0x4 -> ERROR.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FILL  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_RUN   = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    localparam logic [31:0] FETCH_IDLE_WORD = 32'h0;

endpackage

// File: rtl/prog_loader_mem.sv
// Instruction store: one synchronous write port, asynchronous read port.
module prog_loader_mem #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clock,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_waddr,
    input  logic [31:0]           i_wdata,
    input  logic [DEPTH_LOG2-1:0] i_raddr,
    output logic [31:0]           o_rdata
);

    logic [31:0] r_store [2**DEPTH_LOG2];

    // Contents survive reset; the next load rewrites every entry.
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_store[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_store[i_raddr];

endmodule

// File: rtl/prog_loader.sv
// Streams a program into the instruction store, zero-fills the rest, then releases core reset.
// Optional checksum check of the loaded image: define PROG_LOADER_CHECKSUM_EN.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8,
    parameter int RESET_HOLD = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [31:0]           load_data,
    input  logic                  load_last,
    input  logic [31:0]           fetch_addr,
    output logic [31:0]           fetch_instr,
    output logic                  core_reset,
    output logic [DEPTH_LOG2:0]   loaded_words,
    output logic                  load_error,
`ifdef PROG_LOADER_CHECKSUM_EN
    input  logic [31:0]           load_checksum,
`endif
    output state_t                o_dbg_state
);

    // Handshake: a word transfers on a rising edge where load_valid and load_ready are both 1.
    // load_ready is 1 only in IDLE and LOAD; load_data/load_last are don't-care otherwise.
    localparam logic [DEPTH_LOG2-1:0] LAST_IDX  = '1;
    localparam logic [3:0]            HOLD_LAST = 4'(RESET_HOLD - 1);

    state_t                r_state;
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [3:0]            r_hold;
    logic                  r_error;
    logic                  r_core_reset;
    logic                  r_load_ready;

    logic                  w_accept;
    logic                  w_fill;
    logic                  w_wrap;
    logic                  w_we;
    logic [31:0]           w_wdata;
    logic [31:0]           w_rdata;
    logic                  w_csum_ok;
    logic                  w_unused_addr;

    assign w_accept = load_valid & r_load_ready;
    assign w_fill   = (r_state == ST_FILL);
    assign w_wrap   = (r_wptr == LAST_IDX);
    assign w_we     = w_accept | w_fill;
    assign w_wdata  = w_fill ? 32'h0 : load_data;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [31:0] r_csum;
    assign w_csum_ok = ((r_csum ^ load_data) == load_checksum);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_csum <= '0;
        end else if (w_accept) begin
            r_csum <= r_csum ^ load_data;
        end
    end
`else
    assign w_csum_ok = 1'b1;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_wptr       <= '0;
            r_count      <= '0;
            r_hold       <= '0;
            r_error      <= 1'b0;
            r_core_reset <= 1'b1;
            r_load_ready <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE, ST_LOAD: begin
                    if (w_accept) begin
                        r_wptr  <= r_wptr + 1'b1;
                        r_count <= r_count + 1'b1;
                        if (load_last) begin
                            r_load_ready <= 1'b0;
                            if (!w_csum_ok) begin
                                r_state <= ST_ERROR;
                                r_error <= 1'b1;
                            end else if (w_wrap) begin
                                // Program occupies every entry: nothing left to zero-fill.
                                r_state <= ST_HOLD;
                            end else begin
                                r_state <= ST_FILL;
                            end
                        end else if (w_wrap) begin
                            r_state      <= ST_ERROR;
                            r_error      <= 1'b1;
                            r_load_ready <= 1'b0;
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_FILL: begin
                    r_wptr <= r_wptr + 1'b1;
                    if (w_wrap) begin
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (r_hold == HOLD_LAST) begin
                        r_state      <= ST_RUN;
                        r_core_reset <= 1'b0;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                ST_RUN, ST_ERROR: begin
                end
                default: begin
                    r_state <= ST_ERROR;
                    r_error <= 1'b1;
                end
            endcase
        end
    end

    prog_loader_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clock   (clock),
        .i_we    (w_we),
        .i_waddr (r_wptr),
        .i_wdata (w_wdata),
        .i_raddr (fetch_addr[DEPTH_LOG2-1:0]),
        .o_rdata (w_rdata)
    );

    // Upper address bits are ignored so the core sees the store wrap.
    assign w_unused_addr = ^fetch_addr[31:DEPTH_LOG2];

    assign fetch_instr  = (r_state == ST_RUN) ? w_rdata : FETCH_IDLE_WORD;
    assign core_reset   = r_core_reset;
    assign load_ready   = r_load_ready;
    assign loaded_words = r_count;
    assign load_error   = r_error;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench: a default-size loader and a 4-entry loader share clock and reset.
module tb_prog_loader;
    import prog_loader_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        b_valid = 1'b0, b_last = 1'b0, b_ready, b_core_reset, b_error;
    logic [31:0] b_data = '0, b_addr = '0, b_instr;
    logic [8:0]  b_words;
    state_t      b_state;

    logic        s_valid = 1'b0, s_last = 1'b0, s_ready, s_core_reset, s_error;
    logic [31:0] s_data = '0, s_addr = '0, s_instr;
    logic [2:0]  s_words;
    state_t      s_state;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [31:0] b_csum = '0, s_csum = '0;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n;

    logic [31:0] prog [9];

    always #5 clock = ~clock;

    prog_loader #(.DEPTH_LOG2(8), .RESET_HOLD(4)) dut (
        .clock(clock), .reset(reset), .load_valid(b_valid), .load_ready(b_ready),
        .load_data(b_data), .load_last(b_last), .fetch_addr(b_addr), .fetch_instr(b_instr),
        .core_reset(b_core_reset), .loaded_words(b_words), .load_error(b_error),
`ifdef PROG_LOADER_CHECKSUM_EN
        .load_checksum(b_csum),
`endif
        .o_dbg_state(b_state)
    );

    prog_loader #(.DEPTH_LOG2(2), .RESET_HOLD(4)) dut_small (
        .clock(clock), .reset(reset), .load_valid(s_valid), .load_ready(s_ready),
        .load_data(s_data), .load_last(s_last), .fetch_addr(s_addr), .fetch_instr(s_instr),
        .core_reset(s_core_reset), .loaded_words(s_words), .load_error(s_error),
`ifdef PROG_LOADER_CHECKSUM_EN
        .load_checksum(s_csum),
`endif
        .o_dbg_state(s_state)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        b_valid = 1'b0; b_last = 1'b0;
        s_valid = 1'b0; s_last = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic big_word(input logic [31:0] d, input logic last);
        b_valid = 1'b1; b_data = d; b_last = last;
        step();
        b_valid = 1'b0; b_last = 1'b0;
    endtask

    task automatic small_word(input logic [31:0] d, input logic last);
        s_valid = 1'b1; s_data = d; s_last = last;
        step();
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic big_wait_run(input string tag);
        int k = 0;
        while (b_state != ST_RUN && k < 400) begin
            step();
            k++;
        end
        chk(tag, 32'(b_state), 32'(ST_RUN));
    endtask

    task automatic big_fetch(input string tag, input logic [31:0] a, input logic [31:0] exp);
        b_addr = a;
        #1;
        chk(tag, b_instr, exp);
    endtask

    initial begin
        prog[0] = 32'h00631826; prog[1] = 32'h2063000a; prog[2] = 32'h00832020;
        prog[3] = 32'h1060fffd; prog[4] = 32'h2084ffff; prog[5] = 32'h00000020;
        prog[6] = 32'hac040000; prog[7] = 32'h08000007; prog[8] = 32'h0040000d;

        // Reset state
        step(); step();
        reset = 1'b0;
        chk("rst_state", 32'(b_state), 32'(ST_IDLE));
        chk("rst_words", 32'(b_words), 32'd0);
        chk("rst_error", 32'(b_error), 32'd0);
        chk("rst_core_reset", 32'(b_core_reset), 32'd1);
        chk("rst_ready", 32'(b_ready), 32'd1);
        chk("rst_instr", b_instr, 32'h0);

        // Nine-word program, back to back
        for (int i = 0; i < 9; i++) begin
            b_valid = 1'b1; b_data = prog[i]; b_last = (i == 8);
            step();
        end
        b_valid = 1'b0; b_last = 1'b0;
        chk("prog_words", 32'(b_words), 32'd9);
        chk("prog_fill_entry", 32'(b_state), 32'(ST_FILL));
        chk("prog_ready_fill", 32'(b_ready), 32'd0);
        n = 0;
        while (b_state == ST_FILL && n < 1000) begin
            step();
            n++;
        end
        chk("prog_fill_cycles", n, 32'd247);
        chk("prog_hold_core_reset", 32'(b_core_reset), 32'd1);
        chk("prog_hold_instr", b_instr, 32'h0);
        n = 0;
        while (b_core_reset && n < 100) begin
            step();
            n++;
        end
        chk("prog_hold_cycles", n, 32'd4);
        chk("prog_run", 32'(b_state), 32'(ST_RUN));
        big_fetch("prog_fetch1", 32'd1, 32'h2063000a);
        big_fetch("prog_fetch8", 32'd8, 32'h0040000d);
        big_fetch("prog_fetch9", 32'd9, 32'h0);
        big_fetch("prog_fetch255", 32'd255, 32'h0);
        big_fetch("wrap_fetch101", 32'h101, 32'h2063000a);
        big_fetch("wrap_fetch_hi", 32'hffff_ff00, 32'h00631826);
        // Offered words in RUN must be ignored
        b_valid = 1'b1; b_data = 32'hdeadbeef; b_last = 1'b1;
        step(); step();
        b_valid = 1'b0; b_last = 1'b0;
        chk("run_ignore_words", 32'(b_words), 32'd9);
        big_fetch("run_ignore_fetch9", 32'd9, 32'h0);

        // Backpressure: valid on every other cycle
        do_reset();
        chk("bp_rst_words", 32'(b_words), 32'd0);
        chk("bp_rst_instr", b_instr, 32'h0);
        for (int i = 0; i < 3; i++) begin
            big_word(32'h1111_0000 + 32'(i), i == 2);
            if (i < 2) begin
                b_data = 32'hbad0_0000 + 32'(i);
                step();
            end
        end
        chk("bp_words", 32'(b_words), 32'd3);
        big_wait_run("bp_run");
        chk("bp_words_run", 32'(b_words), 32'd3);
        big_fetch("bp_fetch0", 32'd0, 32'h1111_0000);
        big_fetch("bp_fetch1", 32'd1, 32'h1111_0001);
        big_fetch("bp_fetch2", 32'd2, 32'h1111_0002);
        big_fetch("bp_fetch3", 32'd3, 32'h0);

        // Reset in the middle of a load, then a 2-word reload
        do_reset();
        for (int i = 0; i < 3; i++) big_word(32'h5555_0000 + 32'(i), 1'b0);
        chk("mid_words_before", 32'(b_words), 32'd3);
        chk("mid_state_before", 32'(b_state), 32'(ST_LOAD));
        do_reset();
        chk("mid_rst_state", 32'(b_state), 32'(ST_IDLE));
        chk("mid_rst_words", 32'(b_words), 32'd0);
        chk("mid_rst_ready", 32'(b_ready), 32'd1);
        big_word(32'hcafe_0001, 1'b0);
        big_word(32'hcafe_0002, 1'b1);
        chk("mid_words", 32'(b_words), 32'd2);
        big_wait_run("mid_run");
        big_fetch("mid_fetch0", 32'd0, 32'hcafe_0001);
        big_fetch("mid_fetch1", 32'd1, 32'hcafe_0002);
        big_fetch("mid_fetch2", 32'd2, 32'h0);
        big_fetch("mid_fetch3", 32'd3, 32'h0);

        // Overflow on the 4-entry loader
        do_reset();
        for (int i = 0; i < 3; i++) begin
            small_word(32'h7000_0000 + 32'(i), 1'b0);
            chk("ovf_no_error_yet", 32'(s_error), 32'd0);
        end
        small_word(32'h7000_0003, 1'b0);
        chk("ovf_state", 32'(s_state), 32'(ST_ERROR));
        chk("ovf_ready", 32'(s_ready), 32'd0);
        chk("ovf_error", 32'(s_error), 32'd1);
        chk("ovf_core_reset", 32'(s_core_reset), 32'd1);
        chk("ovf_words", 32'(s_words), 32'd4);
        small_word(32'h7000_0004, 1'b0);
        step(); step();
        chk("ovf_words_after5", 32'(s_words), 32'd4);
        chk("ovf_error_sticky", 32'(s_error), 32'd1);
        chk("ovf_core_reset_sticky", 32'(s_core_reset), 32'd1);

        // Program exactly filling the 4-entry store skips FILL
        do_reset();
        chk("full_rst_error", 32'(s_error), 32'd0);
        for (int i = 0; i < 4; i++) small_word(32'h6000_0000 + 32'(i), i == 3);
        chk("full_state_hold", 32'(s_state), 32'(ST_HOLD));
        chk("full_words", 32'(s_words), 32'd4);
        step(); step(); step();
        chk("full_core_reset_3", 32'(s_core_reset), 32'd1);
        step();
        chk("full_core_reset_4", 32'(s_core_reset), 32'd0);
        s_addr = 32'd7;
        #1;
        chk("full_fetch_wrap", s_instr, 32'h6000_0003);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Checksum match and mismatch
        do_reset();
        big_word(32'h1, 1'b0);
        b_csum = 32'h3;
        big_word(32'h2, 1'b1);
        chk("csum_ok_state", 32'(b_state), 32'(ST_FILL));
        big_wait_run("csum_ok_run");
        chk("csum_ok_error", 32'(b_error), 32'd0);
        do_reset();
        big_word(32'h1, 1'b0);
        b_csum = 32'h4;
        big_word(32'h2, 1'b1);
        chk("csum_bad_state", 32'(b_state), 32'(ST_ERROR));
        chk("csum_bad_error", 32'(b_error), 32'd1);
        chk("csum_bad_core_reset", 32'(b_core_reset), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
